// File: rtl/pic_pkg.sv
// Shared definitions for the interrupt acknowledge sequencer: level count, vector width,
// spurious level, FSM state encoding and small level/priority helpers.
package pic_pkg;

    localparam int unsigned NUM_LEVELS     = 8;
    localparam int unsigned VECTOR_WIDTH   = 8;
    localparam logic [2:0]  SPURIOUS_LEVEL = 3'd7;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StAck1 = 2'd2,
        StAck2 = 2'd3
    } ack_state_t;

    // Rotation-relative priority: 0 is highest, the level right after lowest_level.
    function automatic logic [2:0] level_priority(input logic [2:0] level,
                                                  input logic [2:0] lowest_level);
        return level - lowest_level - 3'd1;
    endfunction

    // Encode a one-hot level mask; returns 0 for an all-zero mask.
    function automatic logic [2:0] onehot_to_level(input logic [NUM_LEVELS-1:0] onehot);
        logic [2:0] lvl;
        lvl = 3'd0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            if (onehot[i]) lvl = 3'(i);
        end
        return lvl;
    endfunction

endpackage

// File: rtl/interrupt_ack_sequencer_if.sv
// Signal bundle between the sequencer and its surroundings (resolver, CPU bus, OCW logic).
// master: the sequencer itself; slave: the environment driving it.
interface interrupt_ack_sequencer_if;
    import pic_pkg::*;

    logic [NUM_LEVELS-1:0]   resolved_interrupt;
    logic                    inta_n;
    logic [4:0]              vector_base;
    logic                    auto_eoi;
    logic                    eoi_strobe;
    logic                    eoi_specific;
    logic                    rotate_on_eoi;
    logic [2:0]              eoi_level;
    logic                    int_out;
    logic [NUM_LEVELS-1:0]   in_service_register;
    logic [NUM_LEVELS-1:0]   highest_level_in_service;
    logic [NUM_LEVELS-1:0]   clear_irr;
    logic [VECTOR_WIDTH-1:0] vector_out;
    logic                    vector_oe;

    modport master (
        input  resolved_interrupt, inta_n, vector_base, auto_eoi,
               eoi_strobe, eoi_specific, rotate_on_eoi, eoi_level,
        output int_out, in_service_register, highest_level_in_service,
               clear_irr, vector_out, vector_oe
    );

    modport slave (
        output resolved_interrupt, inta_n, vector_base, auto_eoi,
               eoi_strobe, eoi_specific, rotate_on_eoi, eoi_level,
        input  int_out, in_service_register, highest_level_in_service,
               clear_irr, vector_out, vector_oe
    );

endinterface

// File: rtl/isr_priority_finder.sv
// Finds the highest-priority set ISR bit under the current rotation and decides whether a
// candidate request outranks every in-service level.
module isr_priority_finder
    import pic_pkg::*;
(
    input  logic [NUM_LEVELS-1:0] isr,
    input  logic [2:0]            lowest_level,
    input  logic [NUM_LEVELS-1:0] candidate,
    output logic                  isr_any,
    output logic [2:0]            highest_level,
    output logic                  candidate_wins
);

    logic [2:0] lvl;
    logic [2:0] cand_level;

    // Walk from lowest to highest priority so the last hit is the highest-priority bit.
    always_comb begin
        highest_level = 3'd0;
        lvl           = 3'd0;
        for (int p = NUM_LEVELS - 1; p >= 0; p--) begin
            lvl = lowest_level + 3'(p) + 3'd1;
            if (isr[lvl]) highest_level = lvl;
        end
    end

    // Candidate must be strictly higher than every set ISR bit.
    always_comb begin
        isr_any        = |isr;
        cand_level     = onehot_to_level(candidate);
        candidate_wins = (|candidate) &&
                         (!isr_any ||
                          (level_priority(cand_level, lowest_level) <
                           level_priority(highest_level, lowest_level)));
    end

endmodule

// File: rtl/interrupt_ack_sequencer.sv
// 8259-style interrupt acknowledge sequencer: raises INT, runs the two-pulse INTA cycle,
// drives the vector, and maintains ISR and rotation state under EOI commands.
// Optional auto-EOI is compiled in only when PIC_AUTO_EOI_EN is defined.
module interrupt_ack_sequencer #(
    parameter int unsigned NUM_LEVELS = 8
) (
    input logic                        clk,
    input logic                        rst_n,
    interrupt_ack_sequencer_if.master  bus
);
    import pic_pkg::*;

    if (NUM_LEVELS != 8) begin : g_num_levels_check
        $error("interrupt_ack_sequencer supports only NUM_LEVELS == 8");
    end

    ack_state_t  state_q;
    logic        inta_q;
    logic        int_out_q;
    logic [7:0]  isr_q;
    logic [2:0]  lowest_q;
    logic [7:0]  clear_irr_q;
    logic [7:0]  vector_out_q;
    logic        vector_oe_q;
    logic [2:0]  level_q;
    logic        spurious_q;

    logic        inta_fall;
    logic        inta_rise;
    logic        isr_any;
    logic [2:0]  highest_level;
    logic        candidate_wins;
    logic [2:0]  eoi_target;
    logic [7:0]  eoi_clr_mask;
    logic        eoi_rotate;
    logic [7:0]  ack_set_mask;
    logic        auto_clear;
    logic [7:0]  auto_clr_mask;
    logic        auto_rotate;

    assign inta_fall = inta_q & ~bus.inta_n;
    assign inta_rise = ~inta_q & bus.inta_n;

    isr_priority_finder u_finder (
        .isr            (isr_q),
        .lowest_level   (lowest_q),
        .candidate      (bus.resolved_interrupt),
        .isr_any        (isr_any),
        .highest_level  (highest_level),
        .candidate_wins (candidate_wins)
    );

`ifdef PIC_AUTO_EOI_EN
    assign auto_clear = (state_q == StAck2) && inta_rise && bus.auto_eoi && !spurious_q;
`else
    logic unused_auto;
    assign unused_auto = bus.auto_eoi ^ spurious_q;
    assign auto_clear  = 1'b0;
`endif
    assign auto_clr_mask = auto_clear ? (8'b1 << level_q) : 8'b0;
    assign auto_rotate   = auto_clear && bus.rotate_on_eoi;

    // EOI command decode; an empty ISR makes any EOI a no-op.
    always_comb begin
        eoi_target   = 3'd0;
        eoi_clr_mask = 8'b0;
        eoi_rotate   = 1'b0;
        if (bus.eoi_strobe && isr_any) begin
            eoi_target   = bus.eoi_specific ? bus.eoi_level : highest_level;
            eoi_clr_mask = 8'b1 << eoi_target;
            eoi_rotate   = bus.rotate_on_eoi;
        end
    end

    // Non-spurious first INTA sets the acknowledged bit.
    always_comb begin
        ack_set_mask = 8'b0;
        if (state_q == StReq && inta_fall) ack_set_mask = bus.resolved_interrupt;
    end

    // Acknowledge FSM with registered outputs, ISR and rotation state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            inta_q       <= 1'b1;
            int_out_q    <= 1'b0;
            isr_q        <= 8'b0;
            lowest_q     <= SPURIOUS_LEVEL;
            clear_irr_q  <= 8'b0;
            vector_out_q <= 8'b0;
            vector_oe_q  <= 1'b0;
            level_q      <= 3'd0;
            spurious_q   <= 1'b0;
        end else begin
            inta_q      <= bus.inta_n;
            clear_irr_q <= 8'b0;
            // Set wins over a clear of the same bit.
            isr_q       <= (isr_q & ~(eoi_clr_mask | auto_clr_mask)) | ack_set_mask;
            if (eoi_rotate) begin
                lowest_q <= eoi_target;
            end else if (auto_rotate) begin
                lowest_q <= level_q;
            end

            unique case (state_q)
                StIdle: begin
                    if (candidate_wins) begin
                        state_q   <= StReq;
                        int_out_q <= 1'b1;
                    end
                end
                StReq: begin
                    if (inta_fall) begin
                        int_out_q <= 1'b0;
                        state_q   <= StAck1;
                        if (|bus.resolved_interrupt) begin
                            level_q     <= onehot_to_level(bus.resolved_interrupt);
                            spurious_q  <= 1'b0;
                            clear_irr_q <= bus.resolved_interrupt;
                        end else begin
                            level_q    <= SPURIOUS_LEVEL;
                            spurious_q <= 1'b1;
                        end
                    end
                end
                StAck1: begin
                    if (inta_fall) begin
                        vector_out_q <= {bus.vector_base, level_q};
                        vector_oe_q  <= 1'b1;
                        state_q      <= StAck2;
                    end
                end
                StAck2: begin
                    if (inta_rise) begin
                        vector_oe_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.int_out                  = int_out_q;
    assign bus.in_service_register      = isr_q;
    assign bus.highest_level_in_service = 8'b1 << lowest_q;
    assign bus.clear_irr                = clear_irr_q;
    assign bus.vector_out               = vector_out_q;
    assign bus.vector_oe                = vector_oe_q;

endmodule

// File: tb/tb_interrupt_ack_sequencer.sv
// Directed bench for interrupt_ack_sequencer; expected vectors go through a scoreboard queue.
module tb_interrupt_ack_sequencer;
    import pic_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;
    logic [7:0] exp_q[$];

    interrupt_ack_sequencer_if bus();

    interrupt_ack_sequencer #(.NUM_LEVELS(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef PIC_AUTO_EOI_EN
    localparam logic [7:0] AUTO_ISR = 8'h00;
`else
    localparam logic [7:0] AUTO_ISR = 8'h08;
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic eoi(input logic specific, input logic [2:0] lvl, input logic rot);
        bus.eoi_strobe    = 1'b1;
        bus.eoi_specific  = specific;
        bus.eoi_level     = lvl;
        bus.rotate_on_eoi = rot;
        step();
        bus.eoi_strobe    = 1'b0;
        bus.rotate_on_eoi = 1'b0;
    endtask

    task automatic wait_vec(input string tag);
        int n;
        logic [7:0] exp;
        n = 0;
        while (bus.vector_oe !== 1'b1 && n < 8) begin
            step();
            n++;
        end
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
        chk({tag, "_oe_latency"}, n, 0);
        chk({tag, "_vector_out"}, bus.vector_out, exp);
    endtask

    // Full two-pulse INTA cycle; the resolver drops its request after the first pulse.
    task automatic run_ack(input string tag, input logic [7:0] vec,
                           input logic [7:0] exp_clr, input logic [7:0] exp_isr);
        exp_q.push_back(vec);
        bus.inta_n = 1'b0;
        step();
        chk({tag, "_clear_irr"}, bus.clear_irr, exp_clr);
        chk({tag, "_isr_set"}, bus.in_service_register, exp_isr);
        chk({tag, "_int_off"}, bus.int_out, 0);
        bus.resolved_interrupt = 8'h00;
        step();
        chk({tag, "_clear_irr_pulse"}, bus.clear_irr, 0);
        bus.inta_n = 1'b1;
        step();
        bus.inta_n = 1'b0;
        step();
        wait_vec(tag);
        step();
        bus.inta_n = 1'b1;
        step();
        chk({tag, "_oe_off"}, bus.vector_oe, 0);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        bus.resolved_interrupt = 8'h00;
        bus.inta_n        = 1'b1;
        bus.vector_base   = 5'h10;
        bus.auto_eoi      = 1'b0;
        bus.eoi_strobe    = 1'b0;
        bus.eoi_specific  = 1'b0;
        bus.rotate_on_eoi = 1'b0;
        bus.eoi_level     = 3'd0;
        step();
        step();
        chk("rst_int_out", bus.int_out, 0);
        chk("rst_isr", bus.in_service_register, 0);
        chk("rst_hlis", bus.highest_level_in_service, 8'h80);
        chk("rst_clear_irr", bus.clear_irr, 0);
        chk("rst_vector_out", bus.vector_out, 0);
        chk("rst_vector_oe", bus.vector_oe, 0);

        // Basic acknowledge of level 2.
        rst_n = 1'b1;
        bus.resolved_interrupt = 8'h04;
        step();
        chk("l2_int_out", bus.int_out, 1);
        run_ack("l2", 8'h82, 8'h04, 8'h04);
        chk("l2_isr_kept", bus.in_service_register, 8'h04);

        // Lower priority blocked, higher priority nests.
        bus.resolved_interrupt = 8'h10;
        step();
        step();
        chk("l4_blocked", bus.int_out, 0);
        bus.resolved_interrupt = 8'h01;
        step();
        chk("l0_int_out", bus.int_out, 1);
        run_ack("l0", 8'h80, 8'h01, 8'h05);
        eoi(1'b1, 3'd0, 1'b0);
        chk("spec_eoi_l0", bus.in_service_register, 8'h04);

        // Request withdrawn before INTA: spurious level 7.
        bus.resolved_interrupt = 8'h02;
        step();
        chk("l1_int_out", bus.int_out, 1);
        bus.resolved_interrupt = 8'h00;
        step();
        chk("withdrawn_int_held", bus.int_out, 1);
        run_ack("spur", 8'h87, 8'h00, 8'h04);
        chk("spur_isr", bus.in_service_register, 8'h04);

        // Build ISR=14, then non-specific EOI with rotation.
        eoi(1'b0, 3'd0, 1'b0);
        chk("nonspec_eoi_clear", bus.in_service_register, 8'h00);
        bus.resolved_interrupt = 8'h10;
        step();
        chk("l4_int_out", bus.int_out, 1);
        run_ack("l4", 8'h84, 8'h10, 8'h10);
        bus.resolved_interrupt = 8'h04;
        step();
        chk("l2b_int_out", bus.int_out, 1);
        run_ack("l2b", 8'h82, 8'h04, 8'h14);
        eoi(1'b0, 3'd0, 1'b1);
        chk("rot_eoi_isr", bus.in_service_register, 8'h10);
        chk("rot_eoi_hlis", bus.highest_level_in_service, 8'h04);

        // Auto-EOI on the second INTA rise (compiled in only with the macro).
        eoi(1'b1, 3'd4, 1'b0);
        chk("spec_eoi_l4", bus.in_service_register, 8'h00);
        bus.auto_eoi = 1'b1;
        bus.resolved_interrupt = 8'h08;
        step();
        chk("l3_int_out", bus.int_out, 1);
        run_ack("l3", 8'h83, 8'h08, 8'h08);
        chk("auto_eoi_isr", bus.in_service_register, AUTO_ISR);
        bus.auto_eoi = 1'b0;
        eoi(1'b1, 3'd3, 1'b0);
        chk("l3_cleanup", bus.in_service_register, 8'h00);
        eoi(1'b0, 3'd0, 1'b1);
        chk("empty_eoi_hlis", bus.highest_level_in_service, 8'h04);
        chk("empty_eoi_isr", bus.in_service_register, 8'h00);

        // Reset in ACK2 aborts the sequence.
        bus.resolved_interrupt = 8'h01;
        step();
        chk("l0b_int_out", bus.int_out, 1);
        bus.inta_n = 1'b0;
        step();
        bus.resolved_interrupt = 8'h00;
        step();
        bus.inta_n = 1'b1;
        step();
        bus.inta_n = 1'b0;
        step();
        chk("ack2_oe", bus.vector_oe, 1);
        rst_n = 1'b0;
        step();
        chk("abort_oe", bus.vector_oe, 0);
        chk("abort_state", 32'(dut.state_q), 32'(StIdle));
        chk("abort_isr", bus.in_service_register, 8'h00);
        chk("abort_hlis", bus.highest_level_in_service, 8'h80);
        chk("abort_int_out", bus.int_out, 0);
        bus.inta_n = 1'b1;
        rst_n = 1'b1;
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/interrupt_ack_sequencer.md
INTERRUPT_ACK_SEQUENCER -- requirements
Module: interrupt_ack_sequencer

Interface
REQ-001 SHALL have parameter NUM_LEVELS, default 8, number of interrupt levels; only 8 is supported.
REQ-002 SHALL have port clk  in  1  single system clock; all state changes on rising edge.
REQ-003 SHALL have port rst_n  in  1  synchronous, active-low reset, sampled on clk rising edge.
REQ-004 SHALL have port resolved_interrupt  in  8  one-hot (or zero) winning request from the priority resolver.
REQ-005 SHALL have port inta_n  in  1  CPU interrupt-acknowledge strobe, active-low, already synchronous to clk.
REQ-006 SHALL have port vector_base  in  5  ICW2 bits T7..T3.
REQ-007 SHALL have port auto_eoi  in  1  auto-EOI mode select.
REQ-008 SHALL have port eoi_strobe, eoi_specific, rotate_on_eoi  in  1 each  OCW2 command pulse (one cycle) and its mode bits.
REQ-009 SHALL have port eoi_level  in  3  level cleared by a specific EOI.
REQ-010 SHALL have port int_out  out  1  interrupt request to CPU.
REQ-011 SHALL have port in_service_register  out  8  ISR.
REQ-012 SHALL have port highest_level_in_service  out  8  one-hot lowest-priority level; drives the resolver's rotation.
REQ-013 SHALL have port clear_irr  out  8  one-cycle pulse clearing the acknowledged IRR bit.
REQ-014 SHALL have port vector_out  out  8  interrupt vector; vector_oe  out  1  data-bus drive enable.

Function
REQ-015 SHALL detect an inta_n falling edge as a registered previous value of 1 and a current value of 0; rising edges are detected likewise.
REQ-016 SHALL implement the FSM IDLE -> REQ -> ACK1 -> ACK2 -> IDLE.
REQ-017 In IDLE, SHALL go to REQ and set int_out on the next cycle when resolved_interrupt is nonzero and its priority is strictly higher than every set ISR bit.
REQ-018 SHALL compute priority as (level - lowest_level - 1) mod 8, where 0 is highest.
REQ-019 In REQ, on an inta_n fall, SHALL latch the level, set its ISR bit, pulse clear_irr for exactly one cycle, clear int_out, and enter ACK1.
REQ-020 In REQ, if resolved_interrupt == 0 at the inta_n fall, SHALL treat the acknowledge as spurious: level 7, no ISR set, no clear_irr.
REQ-021 If the request is withdrawn in REQ before INTA, SHALL keep int_out asserted until the first INTA (spurious path).
REQ-022 In ACK1, on the second inta_n fall, SHALL set vector_out = {vector_base, level[2:0]}, set vector_oe=1, and enter ACK2.
REQ-023 In ACK2, on an inta_n rise, SHALL clear vector_oe and return to IDLE.
REQ-024 On the inta_n rise in ACK2, when auto_eoi=1 and the acknowledge was not spurious, SHALL also clear the latched ISR bit.
REQ-025 SHALL give vector_oe a latency of 1 cycle after the sampled inta_n fall.
REQ-026 On eoi_strobe with eoi_specific=0 (non-specific EOI), SHALL clear the highest-priority set ISR bit.
REQ-027 On eoi_strobe with eoi_specific=1, SHALL clear ISR[eoi_level].
REQ-028 On any EOI with ISR == 0, SHALL take no action.
REQ-029 When rotate_on_eoi=1, SHALL set lowest_level to the cleared level, also on the auto-EOI path.
REQ-030 SHALL drive highest_level_in_service = 1 << lowest_level.
REQ-031 When an ACK set and an EOI clear fall in the same cycle, SHALL apply both; if both target the same bit, the set wins.
REQ-032 SHALL ignore inta_n edges in IDLE.
REQ-033 SHALL ignore inta_n edges that do not match the current state.

Reset
REQ-034 On rst_n=0, SHALL return to IDLE and drive int_out=0, in_service_register=0, clear_irr=0, vector_out=0, vector_oe=0, and lowest_level=7 (highest_level_in_service=8'h80).
REQ-035 Reset mid-acknowledge SHALL abort the sequence; vector_oe SHALL be low in the cycle after reset is sampled.

Configuration
REQ-036 SHALL compile the auto-EOI feature only when macro PIC_AUTO_EOI_EN is defined.
REQ-037 When PIC_AUTO_EOI_EN is defined, SHALL behave as REQ-024.
REQ-038 When PIC_AUTO_EOI_EN is undefined, the auto_eoi port SHALL remain and be ignored; ISR bits SHALL clear only by EOI commands.

Structure
REQ-039 Shared package pic_pkg SHALL hold the FSM state encoding, NUM_LEVELS, the vector width, and the spurious level constant (7).
REQ-040 One sub-module, isr_priority_finder, SHALL provide highest-priority set ISR bit and rotation-relative priority comparison; instantiated for the EOI and REQ-017 checks.

Verification
REQ-041 SHALL cover: reset, resolved=8'h04, ISR=0 -> int_out=1, two INTA pulses, vector_base=5'h10 -> clear_irr=8'h04 one cycle, ISR=8'h04, vector_out=8'h82.
REQ-042 SHALL cover: ISR=8'h04, resolved=8'h10 -> int_out stays 0; resolved=8'h01 -> int_out=1.
REQ-043 SHALL cover: int_out=1, then resolved=0 before INTA -> vector_out={vector_base,3'b111}, ISR unchanged, clear_irr=0.
REQ-044 SHALL cover: ISR=8'h14, non-specific EOI with rotate_on_eoi=1 -> ISR=8'h10, highest_level_in_service=8'h04.
REQ-045 SHALL cover: auto_eoi=1 with PIC_AUTO_EOI_EN defined -> ISR returns to 0 on the second INTA rise; with the macro undefined -> ISR stays set.
REQ-046 SHALL cover: rst_n=0 in ACK2 -> vector_oe=0 next cycle, state IDLE, ISR=0.
